// File: rtl/dmem_sized_if.sv
// dmem_sized_if -- request/response bundle for the sized data memory.
//
// Master side (CPU / bench) drives:
//   req           request strobe, taken when ready=1 at a rising clock edge
//   mem_write     1 = store, 0 = load
//   size          00 byte, 01 halfword, 10 word, 11 reserved
//   unsigned_load 1 = zero-extend sub-word loads, 0 = sign-extend
//   address       byte address (upper bits beyond the decoded width wrap)
//   write_data    store data, right-aligned
// Slave side (memory) drives:
//   ready         request can be accepted this cycle
//   busy          power-up clear sequence running
//   read_valid    one-cycle pulse, read_data holds a completed load
//   read_data     extended load result, held until the next completed load
//   misaligned    one-cycle pulse, the previous accepted request was rejected
interface dmem_sized_if;
  logic        req;
  logic        mem_write;
  logic [1:0]  size;
  logic        unsigned_load;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        ready;
  logic        busy;
  logic        read_valid;
  logic [31:0] read_data;
  logic        misaligned;

  modport master (
    output req, mem_write, size, unsigned_load, address, write_data,
    input  ready, busy, read_valid, read_data, misaligned
  );

  modport slave (
    input  req, mem_write, size, unsigned_load, address, write_data,
    output ready, busy, read_valid, read_data, misaligned
  );
endinterface

// File: rtl/dmem_sized.sv
// dmem_sized -- byte/halfword/word addressable data memory with optional
// power-up clear and one-cycle load latency.
//
// Ports:
//   clk_i   single clock, all state changes on its rising edge
//   rst_ni  asynchronous active-low reset
//   bus     dmem_sized_if slave modport (request in, response out)
// Parameters:
//   ADDR_W      byte-address bits decoded; 2^(ADDR_W-2) 32-bit words
//   INIT_CLEAR  1 = zero every word after reset, 0 = leave contents undefined
//
// The array is built as four byte-wide lanes so sub-word stores become plain
// per-lane write enables and each lane maps onto an inferred RAM with a
// registered read port. Sign/zero extension is applied after the RAM output
// register, so the load result appears exactly one cycle after acceptance.
module dmem_sized #(
  parameter int ADDR_W     = 16,
  parameter bit INIT_CLEAR = 1'b1
) (
  input logic       clk_i,
  input logic       rst_ni,
  dmem_sized_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             clr_last;
  logic             ready;
  logic             busy;
  logic             clr_we;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  assign clr_last = &clr_idx_q;

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        // Index wraps back to 0 after the last word, ready for a later reset.
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_last) state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Qualifying with rst_ni keeps ready low and blocks every write while reset
  // is held, even when INIT_CLEAR=0 parks the FSM in IDLE.
  always_comb begin
    ready  = 1'b0;
    busy   = 1'b0;
    clr_we = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = rst_ni;
      end
      default: ready = rst_ni;
    endcase
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;

  // ---------------- request decode ----------------
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       lane;
  logic             aligned;
  logic             accept;
  logic             do_store;
  logic             do_load;
  logic             unused_addr;

  assign req_idx     = bus.address[ADDR_W-1:2];
  assign lane        = bus.address[1:0];
  assign unused_addr = ^bus.address[31:ADDR_W];

  always_comb begin
    case (bus.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~lane[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign accept   = bus.req & ready;
  assign do_store = accept & aligned & bus.mem_write;
  assign do_load  = accept & aligned & ~bus.mem_write;

  // ---------------- shared write port ----------------
  // Sub-word data is replicated across lanes; the byte enables pick the lane.
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [31:0]      wdata;
  logic [3:0]       be;

  always_comb begin
    we    = 1'b0;
    waddr = req_idx;
    wdata = bus.write_data;
    be    = 4'b0000;
    if (clr_we) begin
      we    = 1'b1;
      waddr = clr_idx_q;
      wdata = '0;
      be    = 4'b1111;
    end else if (do_store) begin
      we = 1'b1;
      case (bus.size)
        2'b00: begin
          wdata = {4{bus.write_data[7:0]}};
          be    = 4'b0001 << lane;
        end
        2'b01: begin
          wdata = {2{bus.write_data[15:0]}};
          be    = lane[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata = bus.write_data;
          be    = 4'b1111;
        end
      endcase
    end
  end

  // ---------------- byte-lane RAMs ----------------
  logic [31:0] rd_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    // Only one request is taken per cycle, so a load never shares an edge
    // with a store; a load on the following edge sees the stored bytes.
    always_ff @(posedge clk_i) begin
      if (we && be[gi]) mem_q[waddr] <= wdata[8*gi +: 8];
      if (do_load)      rd_q         <= mem_q[req_idx];
    end

    assign rd_word[8*gi +: 8] = rd_q;
  end

  // ---------------- response ----------------
  logic        read_valid_q;
  logic        misaligned_q;
  logic [1:0]  rd_lane_q;
  logic [1:0]  rd_size_q;
  logic        rd_uns_q;
  logic [31:0] hold_q;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      rd_lane_q    <= 2'b00;
      rd_size_q    <= 2'b00;
      rd_uns_q     <= 1'b0;
      hold_q       <= '0;
    end else begin
      read_valid_q <= do_load;
      misaligned_q <= accept & ~aligned;
      if (do_load) begin
        rd_lane_q <= lane;
        rd_size_q <= bus.size;
        rd_uns_q  <= bus.unsigned_load;
      end
      // Capture the result so read_data stays put after the valid pulse.
      if (read_valid_q) hold_q <= load_ext;
    end
  end

  always_comb begin
    case (rd_lane_q)
      2'd0:    load_byte = rd_word[7:0];
      2'd1:    load_byte = rd_word[15:8];
      2'd2:    load_byte = rd_word[23:16];
      default: load_byte = rd_word[31:24];
    endcase
    load_half = rd_lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (rd_size_q)
      2'b00:   load_ext = {{24{~rd_uns_q & load_byte[7]}}, load_byte};
      2'b01:   load_ext = {{16{~rd_uns_q & load_half[15]}}, load_half};
      default: load_ext = rd_word;
    endcase
  end

  assign bus.read_valid = read_valid_q;
  assign bus.misaligned = misaligned_q;
  assign bus.read_data  = read_valid_q ? load_ext : hold_q;

endmodule

// File: doc/dmem_sized.md
DMEM_SIZED -- requirements
Module: dmem_sized

Interface
REQ-001 Parameter ADDR_W, default 16: byte-address bits decoded; the word array holds 2^(ADDR_W-2) 32-bit words.
REQ-002 Parameter INIT_CLEAR, default 1: 1 = zero every word after reset; 0 = skip clearing, array contents undefined.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 rstN  input  1  reset, asynchronous and active-low.
REQ-005 req  input  1  request strobe; accepted when req=1 and ready=1 at a rising edge.
REQ-006 memWrite  input  1  1 = store, 0 = load; sampled with req.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 unsignedLoad  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-009 address  input  32  byte address; bits [31:ADDR_W] ignored (wrap).
REQ-010 writeData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 ready  output  1  block accepts a request this cycle.
REQ-012 busy  output  1  power-up clear in progress.
REQ-013 readValid  output  1  one-cycle pulse: readData holds a completed load.
REQ-014 readData  output  32  extended load result.
REQ-015 misaligned  output  1  one-cycle pulse: last accepted request was rejected.

Function
REQ-016 States: CLEAR, IDLE; ready = (state==IDLE), busy = (state==CLEAR).
REQ-017 On reset release, the FSM enters CLEAR if INIT_CLEAR=1, otherwise IDLE.
REQ-018 CLEAR: one word per cycle, index 0 up to 2^(ADDR_W-2)-1, written to zero; after the last word -> IDLE; requests during CLEAR are ignored.
REQ-019 Word index = address[ADDR_W-1:2]; byte lane = address[1:0].
REQ-020 Rejection rule: halfword with address[0]=1, word with address[1:0]!=00, or size=11.
REQ-021 Rejected request: no array change; misaligned=1, readValid=0 in the following cycle.
REQ-022 Byte store: writes only lane address[1:0] with writeData[7:0]; other lanes unchanged.
REQ-023 Halfword store: writes lanes {address[1],1} and {address[1],0} with writeData[15:0]; other lanes unchanged.
REQ-024 Word store: writes all four lanes with writeData.
REQ-025 Stores commit at the accepting edge and never assert readValid.
REQ-026 Load latency: exactly 1 cycle; readValid=1 in the cycle after acceptance.
REQ-027 Load data: byte = lane address[1:0]; half = lanes {address[1],x}; word = entire word.
REQ-028 Extension: unsignedLoad=0 replicates the result MSB into bits 31 up to 8 (byte) or 31 up to 16 (half); unsignedLoad=1 fills those bits with zero.
REQ-029 A load accepted the cycle after a store to the same word returns the stored data.
REQ-030 Back-to-back requests are accepted every cycle in IDLE; ready stays 1.
REQ-031 readData holds its value until the next completed load; only loads update it.
REQ-032 readValid and misaligned are never 1 in the same cycle.

Reset
REQ-033 rstN=0 forces at once: state CLEAR (INIT_CLEAR=1) or IDLE (INIT_CLEAR=0), clear index 0, readValid=0, misaligned=0, readData=0, ready=0.
REQ-034 Reset during CLEAR or during a load cancels the pending response; clearing restarts from index 0 after release.
REQ-035 Array contents are not reset directly; only the CLEAR sequence zeros them.

Verification
REQ-036 Reset then release, ADDR_W=6 -> busy=1 for exactly 16 cycles, then ready=1; a word load from 0x3C returns 0x00000000.
REQ-037 Word store 0x8899AABB @0x10, then byte store 0xF0 @0x11 -> word load @0x10 = 0x8899F0BB; signed byte load @0x11 = 0xFFFFFFF0; unsigned = 0x000000F0.
REQ-038 Half store 0x8001 @0x22 -> signed half load @0x22 = 0xFFFF8001; unsigned = 0x00008001; half load @0x20 = original low half.
REQ-039 Word store @0x13, half load @0x21, size=11 @0x00 -> each gives misaligned=1 for one cycle, readValid=0, array unchanged.
REQ-040 Store 0x12345678 @0x04 then, on the next cycle, load @0x04 -> readValid one cycle later with 0x12345678; ADDR_W=6 load @0x44 also returns 0x12345678 (wrap).
REQ-041 rstN pulsed low mid-CLEAR (index 7) -> outputs reset immediately; busy restarts and lasts the full 2^(ADDR_W-2) cycles.
